// File: rtl/mips_pkg.sv
// Shared MIPS definitions: multiply/divide opcode encoding and sequencer states.
package mips_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } muldiv_state_t;

endpackage

// File: rtl/mips_cpu_muldiv.sv
// Iterative MIPS HI/LO multiply/divide unit: one shift-add or restoring-divide step per cycle.
// Define MULDIV_SIGNED_EN to enable MULT/DIV sign handling; otherwise they behave as MULTU/DIVU.
module mips_cpu_muldiv
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_write,
  input  logic             lo_write,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  muldiv_state_t    state;
  muldiv_op_t       op_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc, mq, dvs, a_q;
  logic             b_zero_q;
  logic             signed_in;
  logic [WIDTH:0]   shifted, diff, sum;
  logic [WIDTH-1:0] step_acc, step_mq;
  logic [WIDTH-1:0] res_hi, res_lo;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? negate(x) : x;
  endfunction

`ifdef MULDIV_SIGNED_EN
  logic neg_q, a_neg_q;

  function automatic logic [2*WIDTH-1:0] negate_wide(input logic [2*WIDTH-1:0] x);
    return ~x + (2*WIDTH)'(1);
  endfunction

  assign signed_in = op[0];
`else
  logic unused_op_bit;
  assign signed_in     = 1'b0;
  assign unused_op_bit = op_q[0];
`endif

  assign busy = (state == ST_CALC) || (state == ST_FIX);

  // acc/mq form a double-width shift pair: product for multiply, remainder/quotient for divide
  always_comb begin
    shifted = {acc, mq[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    sum     = {1'b0, acc} + (mq[0] ? {1'b0, dvs} : '0);
    if (op_q[1]) begin
      step_acc = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      step_mq  = {mq[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      step_acc = sum[WIDTH:1];
      step_mq  = {sum[0], mq[WIDTH-1:1]};
    end
  end

  // Division by zero bypasses the datapath so hi returns the original dividend
  always_comb begin
    res_hi = acc;
    res_lo = mq;
    if (!op_q[1]) begin
`ifdef MULDIV_SIGNED_EN
      {res_hi, res_lo} = neg_q ? negate_wide({acc, mq}) : {acc, mq};
`else
      {res_hi, res_lo} = {acc, mq};
`endif
    end else if (b_zero_q) begin
      res_hi = a_q;
      res_lo = '1;
    end else begin
`ifdef MULDIV_SIGNED_EN
      res_hi = a_neg_q ? negate(acc) : acc;
      res_lo = neg_q ? negate(mq) : mq;
`else
      res_hi = acc;
      res_lo = mq;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= OP_MULTU;
      cnt      <= '0;
      acc      <= '0;
      mq       <= '0;
      dvs      <= '0;
      a_q      <= '0;
      b_zero_q <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_q    <= 1'b0;
      a_neg_q  <= 1'b0;
`endif
    end else if (clk_enable) begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q     <= muldiv_op_t'(op);
            a_q      <= a;
            b_zero_q <= (b == '0);
            acc      <= '0;
            mq       <= magnitude(a, signed_in);
            dvs      <= magnitude(b, signed_in);
            cnt      <= CNT_W'(WIDTH);
            state    <= ST_CALC;
`ifdef MULDIV_SIGNED_EN
            a_neg_q  <= signed_in & a[WIDTH-1];
            neg_q    <= signed_in & (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
          end else begin
            if (hi_write) hi <= wdata;
            if (lo_write) lo <= wdata;
          end
        end
        ST_CALC: begin
          acc <= step_acc;
          mq  <= step_mq;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= ST_FIX;
        end
        ST_FIX: begin
          hi    <= res_hi;
          lo    <= res_lo;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Scoreboard bench for mips_cpu_muldiv; expectations follow MULDIV_SIGNED_EN when it is defined.
module tb_mips_cpu_muldiv;

  localparam int W   = 32;
  localparam int LAT = W + 1;
`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk, reset, clk_enable, start, hi_write, lo_write, busy, done;
  logic [1:0]  op;
  logic [31:0] a, b, wdata, hi, lo;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  mips_cpu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op),
    .a(a), .b(b), .hi_write(hi_write), .lo_write(lo_write), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result built from native 64-bit arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic sg;
    longint sx, sy, q, r;
    logic [63:0] p;
    sg = SIGNED_EN && o[0];
    sx = sg ? longint'($signed(x)) : longint'({32'h0, x});
    sy = sg ? longint'($signed(y)) : longint'({32'h0, y});
    if (!o[1]) begin
      q = sx * sy;
      p = q;
    end else if (y == 32'h0) begin
      p = {x, 32'hFFFFFFFF};
    end else begin
      q = sx / sy;
      r = sx % sy;
      p = {r[31:0], q[31:0]};
    end
    return p;
  endfunction

  function automatic exp_t to_exp(input logic [63:0] p);
    exp_t e;
    e.hi = p[63:32];
    e.lo = p[31:0];
    return e;
  endfunction

  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic wr);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    hi_write = wr; lo_write = wr; wdata = 32'hBAD0BAD0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
  endtask

  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && cycles < 200) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: busy/done got %b/%b, expected 0/0", busy, done);
    end
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_hilo: hi/lo got %h/%h, expected 0/0", hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_multiply();
    logic [1:0]  ops [3];
    logic [31:0] av [3], bv [3], eh [3], el [3];
    exp_t e;
    int c, bc;
    ops = '{2'b00, 2'b01, 2'b00};
    av  = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h12345678};
    bv  = '{32'hFFFFFFFF, 32'd7, 32'h10};
`ifdef MULDIV_SIGNED_EN
    eh  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h1};
`else
    eh  = '{32'hFFFFFFFE, 32'h00000006, 32'h1};
`endif
    el  = '{32'h00000001, 32'hFFFFFFEB, 32'h23456780};
    for (int i = 0; i < 3; i++) begin
      e.hi = eh[i];
      e.lo = el[i];
      sb_q.push_back(e);
      applyStimulus(ops[i], av[i], bv[i], 1'b0);
      wait_done(c, bc);
      checks++;
      if (c !== LAT || bc !== LAT) begin
        errors++;
        $display("[TB] FAIL mul_latency[%0d]: done/busy got %0d/%0d cycles, expected %0d/%0d", i, c, bc, LAT, LAT);
      end
      e = sb_q.pop_front();
      checks++;
      if (hi !== e.hi || lo !== e.lo) begin
        errors++;
        $display("[TB] FAIL mul_result[%0d]: hi/lo got %h/%h, expected %h/%h", i, hi, lo, e.hi, e.lo);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL mul_done_pulse[%0d]: done got %b, expected 0", i, done);
      end
    end
  endtask

  task automatic test_divide();
    logic [1:0]  ops [4];
    logic [31:0] av [4], bv [4], eh [4], el [4];
    exp_t e;
    int c, bc;
    ops = '{2'b11, 2'b11, 2'b10, 2'b11};
    av  = '{32'hFFFFFFF9, 32'h80000000, 32'd100, 32'hFFFFFFFB};
    bv  = '{32'd2, 32'hFFFFFFFF, 32'd0, 32'd0};
`ifdef MULDIV_SIGNED_EN
    eh  = '{32'hFFFFFFFF, 32'h00000000, 32'h00000064, 32'hFFFFFFFB};
    el  = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
`else
    eh  = '{32'h00000001, 32'h80000000, 32'h00000064, 32'hFFFFFFFB};
    el  = '{32'h7FFFFFFC, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
`endif
    for (int i = 0; i < 4; i++) begin
      e.hi = eh[i];
      e.lo = el[i];
      sb_q.push_back(e);
      applyStimulus(ops[i], av[i], bv[i], 1'b0);
      wait_done(c, bc);
      checks++;
      if (c !== LAT) begin
        errors++;
        $display("[TB] FAIL div_latency[%0d]: got %0d cycles, expected %0d", i, c, LAT);
      end
      e = sb_q.pop_front();
      checks++;
      if (hi !== e.hi || lo !== e.lo) begin
        errors++;
        $display("[TB] FAIL div_result[%0d]: hi/lo got %h/%h, expected %h/%h", i, hi, lo, e.hi, e.lo);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] x, y;
    exp_t e;
    int c, bc;
    for (int i = 0; i < 10; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = (i == 4) ? 32'h0 : ($urandom >> $urandom_range(0, 28));
      sb_q.push_back(to_exp(model(o, x, y)));
      applyStimulus(o, x, y, 1'b0);
      wait_done(c, bc);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL rand_scoreboard[%0d]: queue empty, expected one entry", i);
      end else begin
        e = sb_q.pop_front();
        checks++;
        if (c !== LAT || hi !== e.hi || lo !== e.lo) begin
          errors++;
          $display("[TB] FAIL rand[%0d] op=%b a=%h b=%h: hi/lo got %h/%h after %0d, expected %h/%h after %0d",
                   i, o, x, y, hi, lo, c, e.hi, e.lo, LAT);
        end
      end
    end
  endtask

  task automatic test_write();
    logic [31:0] prev_lo;
    exp_t e;
    int c, bc;
    prev_lo = lo;
    @(negedge clk);
    hi_write = 1'b1; wdata = 32'h00001234;
    @(negedge clk);
    hi_write = 1'b0;
    checks++;
    if (hi !== 32'h00001234 || lo !== prev_lo) begin
      errors++;
      $display("[TB] FAIL mthi: hi/lo got %h/%h, expected 00001234/%h", hi, lo, prev_lo);
    end
    hi_write = 1'b1; lo_write = 1'b1; wdata = 32'hCAFE0001;
    @(negedge clk);
    hi_write = 1'b0; lo_write = 1'b0;
    checks++;
    if (hi !== 32'hCAFE0001 || lo !== 32'hCAFE0001) begin
      errors++;
      $display("[TB] FAIL mthi_mtlo: hi/lo got %h/%h, expected cafe0001/cafe0001", hi, lo);
    end
    sb_q.push_back(to_exp(model(2'b00, 32'd3, 32'd5)));
    applyStimulus(2'b00, 32'd3, 32'd5, 1'b1);
    checks++;
    if (hi !== 32'hCAFE0001 || lo !== 32'hCAFE0001) begin
      errors++;
      $display("[TB] FAIL start_beats_write: hi/lo got %h/%h, expected cafe0001/cafe0001", hi, lo);
    end
    wait_done(c, bc);
    e = sb_q.pop_front();
    checks++;
    if (hi !== e.hi || lo !== e.lo) begin
      errors++;
      $display("[TB] FAIL start_write_result: hi/lo got %h/%h, expected %h/%h", hi, lo, e.hi, e.lo);
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] pre_hi, pre_lo;
    exp_t e;
    int c, bc, extra;
    pre_hi = hi;
    pre_lo = lo;
    sb_q.push_back(to_exp(model(2'b10, 32'd1000, 32'd7)));
    applyStimulus(2'b10, 32'd1000, 32'd7, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
    hi_write = 1'b1; lo_write = 1'b1; wdata = 32'h5555AAAA;
    @(negedge clk);
    start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
    checks++;
    if (hi !== pre_hi || lo !== pre_lo || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_write_ignored: hi/lo/busy got %h/%h/%b, expected %h/%h/1", hi, lo, busy, pre_hi, pre_lo);
    end
    wait_done(c, bc);
    checks++;
    if (4 + c !== LAT) begin
      errors++;
      $display("[TB] FAIL busy_latency: got %0d cycles, expected %0d", 4 + c, LAT);
    end
    e = sb_q.pop_front();
    checks++;
    if (hi !== e.hi || lo !== e.lo) begin
      errors++;
      $display("[TB] FAIL busy_result: hi/lo got %h/%h, expected %h/%h", hi, lo, e.hi, e.lo);
    end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("[TB] FAIL busy_start_ignored: got %0d extra busy/done cycles, expected 0", extra);
    end
  endtask

  task automatic test_clk_enable();
    logic [31:0] pre_hi;
    exp_t e;
    int c, bc;
    pre_hi = hi;
    sb_q.push_back(to_exp(model(2'b01, 32'hFFFFFF00, 32'h00001234)));
    applyStimulus(2'b01, 32'hFFFFFF00, 32'h00001234, 1'b0);
    repeat (10) @(negedge clk);
    clk_enable = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || hi !== pre_hi) begin
      errors++;
      $display("[TB] FAIL clken_hold: busy/done/hi got %b/%b/%h, expected 1/0/%h", busy, done, hi, pre_hi);
    end
    clk_enable = 1'b1;
    wait_done(c, bc);
    checks++;
    if (15 + c !== LAT + 5) begin
      errors++;
      $display("[TB] FAIL clken_latency: got %0d cycles, expected %0d", 15 + c, LAT + 5);
    end
    e = sb_q.pop_front();
    checks++;
    if (hi !== e.hi || lo !== e.lo) begin
      errors++;
      $display("[TB] FAIL clken_result: hi/lo got %h/%h, expected %h/%h", hi, lo, e.hi, e.lo);
    end
  endtask

  task automatic test_reset_midop();
    exp_t e;
    int c, bc;
    @(negedge clk);
    hi_write = 1'b1; lo_write = 1'b1; wdata = 32'hA5A50001;
    @(negedge clk);
    hi_write = 1'b0; lo_write = 1'b0;
    applyStimulus(2'b10, 32'd5000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_midop: busy/done/hi/lo got %b/%b/%h/%h, expected 0/0/0/0", busy, done, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    op = 2'b10; a = 32'd1000; b = 32'd7; start = 1'b1;
    sb_q.push_back(to_exp(model(2'b10, 32'd1000, 32'd7)));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(c, bc);
    e = sb_q.pop_front();
    checks++;
    if (c !== LAT || hi !== e.hi || lo !== e.lo) begin
      errors++;
      $display("[TB] FAIL post_reset_start: hi/lo got %h/%h after %0d, expected %h/%h after %0d",
               hi, lo, c, e.hi, e.lo, LAT);
    end
  endtask

  initial begin
    reset = 1'b1; clk_enable = 1'b1; start = 1'b0; op = 2'b00;
    a = 32'h0; b = 32'h0; hi_write = 1'b0; lo_write = 1'b0; wdata = 32'h0;
    test_reset();
    test_multiply();
    test_divide();
    test_random();
    test_write();
    test_busy_ignore();
    test_clk_enable();
    test_reset_midop();
    checks++;
    if (sb_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
